bitonic_merge_ctrl: RTL

- Sequencing controller for the 64-element combinational bitonic merge datapath.
- Accepts two ascending 32-element runs as one 64-beat valid/ready stream from the upstream 32-sorters.
- Stores the second run reversed, so the merge input is bitonic: left ascending, right descending.
- Drives the merge unit, waits its configured latency, captures the result and streams 64 sorted words out.

---
 rtl/bitonic_merge_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bitonic_merge_ctrl.sv
// rtl/bitonic_merge_ctrl.sv - load/sort/drain sequencer for a 64-element bitonic merge unit (optional stats: BITONIC_MERGE_CTRL_STATS_EN)
module bitonic_merge_ctrl #(
  parameter int WIDTH     = 32,
  parameter int MERGE_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WIDTH-1:0]    s_data,
  input  logic                s_last,
  input  logic                s_dir,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_last,
  output logic                merge_dir,
  output logic [64*WIDTH-1:0] merge_in_bus,
  input  logic [64*WIDTH-1:0] merge_out_bus,
  output logic                busy,
  output logic                done,
  output logic                err_len
`ifdef BITONIC_MERGE_CTRL_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          err_cnt
`endif
);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam logic [3:0] LAT_LAST = 4'(MERGE_LAT - 1);

  state_t           state, state_nxt;
  logic [5:0]       in_cnt, out_cnt, wr_idx;
  logic [3:0]       lat_cnt;
  logic [WIDTH-1:0] lbuf [64];
  logic [WIDTH-1:0] obuf [64];
  logic             s_hs, m_hs, lat_done, done_nxt, err_nxt;

  assign s_hs = s_valid & (state == LOAD);
  assign m_hs = m_ready & (state == DRAIN);

  // Second run lands mirrored (beat 32+j -> slot 63-j) so the buffer is bitonic.
  assign wr_idx = in_cnt[5] ? {1'b1, ~in_cnt[4:0]} : in_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bus
      assign merge_in_bus[gi*WIDTH +: WIDTH] = lbuf[gi];
    end
  endgenerate

  assign m_data = obuf[out_cnt];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    busy      = 1'b0;
    lat_done  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = (in_cnt != 6'd0);
        if (s_hs) begin
          if (in_cnt == 6'd63) begin
            state_nxt = SORT;
            err_nxt   = ~s_last;
          end else if (s_last) begin
            err_nxt = 1'b1;
          end
        end
      end
      SORT: begin
        busy = 1'b1;
        if (lat_cnt == LAT_LAST) begin
          lat_done  = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = (out_cnt == 6'd63);
        if (m_hs && m_last) begin
          done_nxt  = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Beat, latency and output counters plus registered pulses and direction latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      lat_cnt   <= '0;
      out_cnt   <= '0;
      merge_dir <= 1'b0;
      done      <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      done    <= done_nxt;
      err_len <= err_nxt;
      if (s_hs) begin
        in_cnt <= (in_cnt == 6'd63 || s_last) ? 6'd0 : in_cnt + 6'd1;
        if (in_cnt == 6'd0) merge_dir <= s_dir;
      end
      if (state == SORT) lat_cnt <= lat_done ? 4'd0 : lat_cnt + 4'd1;
      if (m_hs) out_cnt <= m_last ? 6'd0 : out_cnt + 6'd1;
    end
  end

  // Load buffer write and result capture at the end of the merge latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        lbuf[i] <= '0;
        obuf[i] <= '0;
      end
    end else begin
      if (s_hs) lbuf[wr_idx] <= s_data;
      if (lat_done) begin
        for (int i = 0; i < 64; i++) obuf[i] <= merge_out_bus[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef BITONIC_MERGE_CTRL_STATS_EN
  // Completed-frame counter wraps; error counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (done) frame_cnt <= frame_cnt + 16'd1;
      if (err_len && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
